// File: rtl/dump_mem_datos_pkg.sv
// dump_mem_datos_pkg: FSM state encodings and address-width helper shared by the dump scanner.
package dump_mem_datos_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Bits needed to address depth words; never less than one.
    function automatic int clogb2(input int depth);
        int r = 0;
        for (int v = depth - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dump_mem_datos_if.sv
// dump_mem_datos_if: memory, dirty-tracker and consumer signals of the dump scanner.
interface dump_mem_datos_if
    import dump_mem_datos_pkg::*;
#(
    parameter int RAM_DEPTH = 1024,
    parameter int RAM_WIDTH = 32
);
    localparam int AW = clogb2(RAM_DEPTH);

    logic                 i_start;
    logic [AW-1:0]        o_addr;
    logic                 i_bit_sucio;
    logic                 o_ena;
    logic [RAM_WIDTH-1:0] i_data;
    logic                 o_valid;
    logic                 i_ready;
    logic [RAM_WIDTH-1:0] o_dato;
    logic [AW-1:0]        o_dir;
    logic                 o_busy;
    logic                 o_done;
    logic [AW:0]          o_cant_sucios;

    modport master (
        input  i_start, i_bit_sucio, i_data, i_ready,
        output o_addr, o_ena, o_valid, o_dato, o_dir, o_busy, o_done, o_cant_sucios
    );

    modport slave (
        output i_start, i_bit_sucio, i_data, i_ready,
        input  o_addr, o_ena, o_valid, o_dato, o_dir, o_busy, o_done, o_cant_sucios
    );

endinterface

// File: rtl/dump_mem_datos.sv
// dump_mem_datos: scans data memory, reads only dirty words and streams them out with
// valid/ready, reporting how many words were sent.
module dump_mem_datos
    import dump_mem_datos_pkg::*;
#(
    parameter int RAM_DEPTH = 1024,
    parameter int RAM_WIDTH = 32
) (
    input  logic                i_clk,
    input  logic                i_soft_reset,
    dump_mem_datos_if.master    bus
);
    localparam int AW = clogb2(RAM_DEPTH);

    logic [2:0]           state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [RAM_WIDTH-1:0] dato_q, dato_d;
    logic [AW-1:0]        dir_q, dir_d;
    logic [AW:0]          cant_q, cant_d;
    logic                 valid_q, busy_q, done_q;
    logic                 last;

    assign last = cnt_q == AW'(RAM_DEPTH - 1);

    // Address and read enable are combinational so a dirty hit is read in its own CHECK cycle.
    assign bus.o_addr        = (state_q == S_CHECK) ? cnt_q : '0;
    assign bus.o_ena         = (state_q == S_CHECK) && bus.i_bit_sucio;
    assign bus.o_valid       = valid_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_dato        = dato_q;
    assign bus.o_dir         = dir_q;
    assign bus.o_cant_sucios = cant_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dato_d  = dato_q;
        dir_d   = dir_q;
        cant_d  = cant_q;
        case (state_q)
            S_IDLE: if (bus.i_start) begin
                cnt_d   = '0;
                cant_d  = '0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = bus.i_bit_sucio ? S_WAIT : (last ? S_DONE : S_CHECK);
                cnt_d   = (bus.i_bit_sucio || last) ? cnt_q : cnt_q + AW'(1);
            end
            S_WAIT: begin
                dato_d  = bus.i_data;
                dir_d   = cnt_q;
                state_d = S_SEND;
            end
            S_SEND: if (bus.i_ready) begin
                cant_d  = cant_q + (AW+1)'(1);
                cnt_d   = last ? cnt_q : cnt_q + AW'(1);
                state_d = last ? S_DONE : S_CHECK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Flag outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge i_clk or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dato_q  <= '0;
            dir_q   <= '0;
            cant_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dato_q  <= dato_d;
            dir_q   <= dir_d;
            cant_q  <= cant_d;
            valid_q <= state_d == S_SEND;
            busy_q  <= state_d != S_IDLE;
            done_q  <= state_d == S_DONE;
        end
    end

endmodule

// File: doc/dump_mem_datos.md
DUMP_MEM_DATOS -- requirements
Module: dump_mem_datos

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 1024, number of data-memory words scanned.
REQ-002 SHALL have parameter RAM_WIDTH, default 32, data-memory word width.
REQ-003 SHALL derive localparam AW = clogb2(RAM_DEPTH), address width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock, rising edge.
- i_soft_reset  in  1  asynchronous active-low reset.
- i_start  in  1  start-scan request, sampled in IDLE only.
- o_addr  out  AW  address to data memory and dirty-bit tracker.
- i_bit_sucio  in  1  dirty bit for o_addr, combinational from tracker.
- o_ena  out  1  data-memory read enable.
- i_data  in  RAM_WIDTH  memory read data, valid one cycle after o_ena.
- o_valid  out  1  dump word available.
- i_ready  in  1  consumer (debug/UART serializer) accepts word.
- o_dato  out  RAM_WIDTH  dumped word.
- o_dir  out  AW  address of o_dato.
- o_busy  out  1  scan in progress; top muxes memory port to this block.
- o_done  out  1  one-cycle end-of-scan pulse.
- o_cant_sucios  out  AW+1  number of words sent in last scan.

Function
REQ-005 SHALL implement FSM states IDLE, CHECK, WAIT_MEM, SEND, DONE.
REQ-006 IDLE: o_busy=0, o_valid=0, o_ena=0, o_addr=0; i_start=1 -> address counter=0, o_cant_sucios=0, next CHECK.
REQ-007 CHECK: o_busy=1, o_addr=counter; i_bit_sucio=1 -> o_ena=1 same cycle, next WAIT_MEM.
REQ-008 CHECK with i_bit_sucio=0: counter==RAM_DEPTH-1 -> DONE, else counter+1, stay CHECK (one address per cycle).
REQ-009 WAIT_MEM: register i_data into o_dato and counter into o_dir, next SEND.
REQ-010 SEND: o_valid=1; o_dato, o_dir held stable until i_ready=1.
REQ-011 SEND with o_valid&i_ready: o_cant_sucios+1; counter==RAM_DEPTH-1 -> DONE, else counter+1, next CHECK.
REQ-012 DONE: o_done=1 exactly one cycle, o_busy=1, next IDLE; o_cant_sucios held until next i_start.
REQ-013 i_start while not IDLE SHALL be ignored.
REQ-014 Latency: i_start at cycle 0 -> first CHECK cycle 1; dirty address found in CHECK cycle n -> o_valid from cycle n+2.
REQ-015 Clean memory: scan SHALL last RAM_DEPTH CHECK cycles, o_valid never asserted, o_cant_sucios=0.
REQ-016 All-dirty memory: o_cant_sucios SHALL reach RAM_DEPTH without overflow (AW+1 bits).
REQ-017 Counter SHALL never wrap; last address always exits to DONE.
REQ-018 o_ena SHALL be asserted only in CHECK with i_bit_sucio=1.

Reset
REQ-019 i_soft_reset=0 SHALL immediately force IDLE from any state, including mid-SEND.
REQ-020 Reset values: o_valid=0, o_ena=0, o_busy=0, o_done=0, o_addr=0, o_dir=0, o_dato=0, o_cant_sucios=0.
REQ-021 Word pending in SEND at reset SHALL be discarded, not re-sent after reset.

Structure
REQ-022 clogb2 function and state encodings SHALL live in the shared include.
REQ-023 Single module, no sub-modules; all outputs registered except o_addr and o_ena.

Verification
REQ-024 Tracker cleared, i_start -> o_done at cycle RAM_DEPTH+1, o_valid never high, o_cant_sucios=0.
REQ-025 Addresses 3 and 1023 dirty (data 0xDEADBEEF, 0x12345678), i_ready=1 -> two words in order, o_dir=3 then 1023, o_cant_sucios=2.
REQ-026 Address 0 dirty, i_ready low 5 cycles -> o_valid, o_dato, o_dir stable 5 cycles, single transfer on i_ready.
REQ-027 All addresses dirty, i_ready=1 -> RAM_DEPTH words, o_cant_sucios=RAM_DEPTH (1024), no overflow.
REQ-028 i_soft_reset low during SEND -> IDLE same cycle, o_valid=0; i_start pulse during scan -> no restart.
